// File: rtl/fixed_swish_pkg.sv
// fixed_swish_pkg: shared PLAN sigmoid constants and width helpers for fixed_swish_pipelined
package fixed_swish_pkg;
    // Breakpoints are held in eighths so 1.0, 2.375 and 5.0 are all exact integers.
    localparam int BP_FRAC = 3;
    localparam int BP_ONE = 8;
    localparam int BP_MID = 19;
    localparam int BP_SAT = 40;
    // Segment slopes are 2^-SLOPE_*: a/4, a/8, a/32.
    localparam int SLOPE_LO = 2;
    localparam int SLOPE_MID = 3;
    localparam int SLOPE_HI = 5;
    // Offsets are held in 32nds: 0.5, 0.625, 0.84375.
    localparam int OFS_FRAC = 5;
    localparam int OFS_LO = 16;
    localparam int OFS_MID = 20;
    localparam int OFS_HI = 27;

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Signed x times unsigned sigmoid carried as signed with one extra zero bit.
    function automatic int prod_width(input int in_w, input int sig_frac);
        return in_w + sig_frac + 2;
    endfunction
endpackage

// File: rtl/fixed_swish_pipelined_if.sv
// fixed_swish_pipelined_if: N-lane valid/ready stream bundle
// Ports: data [N] lanes of W bits, valid, ready; master drives data/valid, slave drives ready.
interface fixed_swish_pipelined_if #(
    parameter int W = 8,
    parameter int N = 1
);
    logic [W-1:0] data [N];
    logic valid;
    logic ready;
    modport master (output data, output valid, input ready);
    modport slave (input data, input valid, output ready);
endinterface

// File: rtl/fixed_sigmoid_pla.sv
// fixed_sigmoid_pla: combinational one-lane PLAN sigmoid, s = sigmoid(z) truncated to SIGMOID_FRAC bits
// Ports: z signed IN_W bits with IN_FRAC fractional bits; s unsigned SIGMOID_FRAC+1 bits in [0,1].
module fixed_sigmoid_pla
    import fixed_swish_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int IN_FRAC = 4,
    parameter int SIGMOID_FRAC = 8
) (
    input  logic signed [IN_W-1:0] z,
    output logic [SIGMOID_FRAC:0] s
);
    // One spare bit so |z| of the most negative input still fits.
    localparam int AW = IN_W + 1;
    // Exact PLAN value carries the input fraction plus the 1/32 offset resolution.
    localparam int EF = IN_FRAC + OFS_FRAC;
    localparam int CW = (AW + OFS_FRAC + 1 > SIGMOID_FRAC + 2) ? AW + OFS_FRAC + 1 : SIGMOID_FRAC + 2;
    localparam logic [CW-1:0] ONE = CW'(1) << EF;
    logic signed [AW-1:0] zw;
    logic [AW-1:0] a;
    logic [CW-1:0] ac, pos, ex;
    logic lt_one, lt_mid, lt_sat;
    assign zw = {z[IN_W-1], z};
    assign a = zw[AW-1] ? -zw : zw;
    assign ac = CW'(a);
    // Compare a*8 against breakpoint-in-eighths * 2^IN_FRAC so 2.375 is exact at any input fraction.
    assign lt_one = (ac << BP_FRAC) < (CW'(BP_ONE) << IN_FRAC);
    assign lt_mid = (ac << BP_FRAC) < (CW'(BP_MID) << IN_FRAC);
    assign lt_sat = (ac << BP_FRAC) < (CW'(BP_SAT) << IN_FRAC);
    assign pos = !lt_sat ? ONE :
                 !lt_mid ? (ac << (OFS_FRAC - SLOPE_HI)) + (CW'(OFS_HI) << IN_FRAC) :
                 !lt_one ? (ac << (OFS_FRAC - SLOPE_MID)) + (CW'(OFS_MID) << IN_FRAC) :
                           (ac << (OFS_FRAC - SLOPE_LO)) + (CW'(OFS_LO) << IN_FRAC);
    // Symmetry is applied on the exact value, before truncation.
    assign ex = z[IN_W-1] ? ONE - pos : pos;
    localparam int RS = EF - SIGMOID_FRAC;
    if (RS >= 0) begin : g_trunc
        assign s = (SIGMOID_FRAC + 1)'(ex >> RS);
    end else begin : g_ext
        assign s = (SIGMOID_FRAC + 1)'(ex << (-RS));
    end
endmodule

// File: rtl/fixed_swish_pipelined.sv
// fixed_swish_pipelined: 3-stage valid/ready Swish y = x * sigmoid(2^BETA_SHIFT * x), rounded and saturated
// Ports: clk; rst (sync, active-high); data_in_0 slave stream of N signed x lanes;
//        data_out_0 master stream of N swish lanes; data_out_0_sat [N-1:0] per-lane saturation
//        flag, present only when FIXED_SWISH_SAT_FLAG_EN is defined.
module fixed_swish_pipelined
    import fixed_swish_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 4,
    parameter int SIGMOID_FRAC = 8,
    parameter int BETA_SHIFT = 0
) (
    input logic clk,
    input logic rst,
    fixed_swish_pipelined_if.slave data_in_0,
    fixed_swish_pipelined_if.master data_out_0
`ifdef FIXED_SWISH_SAT_FLAG_EN
    ,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] data_out_0_sat
`endif
);
    // Tensor shape is informational; the zero-weighted term only keeps it referenced.
    localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
                       + 0 * (DATA_IN_0_TENSOR_SIZE_DIM_0 + DATA_IN_0_TENSOR_SIZE_DIM_1);
    localparam int IN_W = DATA_IN_0_PRECISION_0;
    localparam int IN_FRAC = DATA_IN_0_PRECISION_1;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int OUT_FRAC = DATA_OUT_0_PRECISION_1;
    localparam int SF = SIGMOID_FRAC;
    // z keeps every bit of x: a left shift grows the integer part, a right shift grows the fraction.
    localparam int ZW = IN_W + iabs(BETA_SHIFT);
    localparam int ZF = IN_FRAC + (BETA_SHIFT < 0 ? -BETA_SHIFT : 0);
    localparam int ZL = BETA_SHIFT > 0 ? BETA_SHIFT : 0;
    localparam int PW = prod_width(IN_W, SF);
    localparam int PF = IN_FRAC + SF;
    localparam int RW = PW + 1 + (OUT_FRAC > PF ? OUT_FRAC - PF : 0);
    localparam int XW = (RW > OUT_W ? RW : OUT_W) + 1;
    localparam logic signed [XW-1:0] MAXV = {{(XW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic v1, v2, v3, load1, load2, load3;
    logic [IN_W-1:0] x1 [N];
    logic [IN_W-1:0] x2 [N];
    logic signed [ZW-1:0] z1 [N];
    logic signed [ZW-1:0] z_d [N];
    logic [SF:0] s2 [N];
    logic [SF:0] s_d [N];
    logic [OUT_W-1:0] y3 [N];
    logic [OUT_W-1:0] y_d [N];
`ifdef FIXED_SWISH_SAT_FLAG_EN
    logic [N-1:0] sat_d;
`endif

    // A stage may load when empty or when its content moves on this edge.
    assign load3 = !v3 || data_out_0.ready;
    assign load2 = !v2 || load3;
    assign load1 = !v1 || load2;
    assign data_in_0.ready = load1;
    assign data_out_0.valid = v3;
    assign data_out_0.data = y3;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [PW-1:0] p;
        logic signed [RW-1:0] r;
        logic signed [XW-1:0] rx;
        logic hi, lo;
        assign z_d[i] = ZW'($signed(data_in_0.data[i])) <<< ZL;
        fixed_sigmoid_pla #(
            .IN_W(ZW),
            .IN_FRAC(ZF),
            .SIGMOID_FRAC(SF)
        ) u_sig (
            .z(z1[i]),
            .s(s_d[i])
        );
        assign p = $signed(x2[i]) * $signed({1'b0, s2[i]});
        if (OUT_FRAC < PF) begin : g_rnd
            logic signed [PW:0] t;
            // Round half up: add half an output LSB, then floor via arithmetic shift.
            assign t = (PW + 1)'(p) + ((PW + 1)'(1) <<< (PF - OUT_FRAC - 1));
            assign r = t >>> (PF - OUT_FRAC);
        end else begin : g_shl
            assign r = RW'(p) <<< (OUT_FRAC - PF);
        end
        assign rx = XW'(r);
        assign hi = rx > MAXV;
        assign lo = rx < MINV;
        assign y_d[i] = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : rx[OUT_W-1:0];
`ifdef FIXED_SWISH_SAT_FLAG_EN
        assign sat_d[i] = hi || lo;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            for (int i = 0; i < N; i++) y3[i] <= '0;
`ifdef FIXED_SWISH_SAT_FLAG_EN
            data_out_0_sat <= '0;
`endif
        end else begin
            if (load1) begin
                v1 <= data_in_0.valid;
                x1 <= data_in_0.data;
                z1 <= z_d;
            end
            if (load2) begin
                v2 <= v1;
                x2 <= x1;
                s2 <= s_d;
            end
            if (load3) begin
                v3 <= v2;
                y3 <= y_d;
`ifdef FIXED_SWISH_SAT_FLAG_EN
                data_out_0_sat <= sat_d;
`endif
            end
        end
    end
endmodule
